// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch stage.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with single-cycle flush; a push may land in the flush cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  fetch_entry_t  i_push_data,
  input  logic          i_pop,
  output fetch_entry_t  o_head,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wr_idx;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_wr_idx = i_flush ? '0 : r_wr_ptr;

  // NOTE: storage is not reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_wr_idx] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= i_push ? ptr_inc('0) : '0;
      r_count  <= CW'(i_push);
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // The credit rule upstream must keep a push from ever meeting a full buffer.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_pop && !i_flush && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, in-order imem reads, instruction buffer, redirect handling.
// Optional IFETCH_MISALIGN_EXC_EN: misaligned redirect targets present a flagged nop instead of fetching.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
`ifdef IFETCH_MISALIGN_EXC_EN
  output logic        if_misaligned,
`endif
  output logic [31:0] if_pc_plus4
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t  r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic          r_exc_hold;

  logic [31:0]   w_redirect_pc;
  logic          w_redirect_mis;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic          w_if_valid;
  logic          w_pop;
  logic [CW:0]   w_credit_used;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_rsp;
  logic          w_rsp_drop;
  logic          w_rsp_push;
  logic          w_push;
  logic [CW-1:0] w_out_next;
  logic [CW-1:0] w_drop_next;

`ifdef IFETCH_MISALIGN_EXC_EN
  assign w_redirect_pc  = redirect_pc;
  assign w_redirect_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign w_redirect_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign w_redirect_mis = 1'b0;
`endif

  assign w_if_valid = !w_fifo_empty && !redirect_valid;
  assign w_pop      = w_if_valid && !stall;

  // Buffered plus in-flight words may never exceed the buffer, so every response has a slot.
  assign w_credit_used = (CW+1)'(w_fifo_count) + (CW+1)'(r_outstanding) - (CW+1)'(w_pop);
  assign w_req_valid   = (r_state == RUN) && !redirect_valid && !r_exc_hold &&
                         (w_credit_used < (CW+1)'(FIFO_DEPTH));
  assign w_accept      = w_req_valid && imem_req_ready;

  assign w_rsp       = imem_rsp_valid && (r_state != IDLE);
  assign w_out_next  = r_outstanding + CW'(w_accept) - CW'(w_rsp);
  assign w_rsp_drop  = w_rsp && (r_drop_cnt != '0);
  assign w_drop_next = r_drop_cnt - CW'(w_rsp_drop);
  assign w_rsp_push  = w_rsp && !w_rsp_drop && !redirect_valid && !r_exc_hold;
  assign w_push      = w_rsp_push || w_redirect_mis;

  always_comb begin
    w_push_data = '{pc: r_rsp_pc, instr: imem_rsp_data, misaligned: 1'b0};
    if (w_redirect_mis) w_push_data = '{pc: w_redirect_pc, instr: NOP_INSTR, misaligned: 1'b1};
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // NOTE: sequential state uses non-blocking assignments so later redirect writes override cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_exc_hold    <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      r_drop_cnt    <= w_drop_next;
      if (w_accept)   r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_rsp_push) r_rsp_pc   <= r_rsp_pc + 32'd4;
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_drop_cnt <= w_out_next;
        r_exc_hold <= w_redirect_mis;
      end
      case (r_state)
        IDLE:    r_state <= RUN;
        RUN:     if (redirect_valid && (w_out_next != '0)) r_state <= DRAIN;
        DRAIN:   if (!redirect_valid && (w_drop_next == '0)) r_state <= RUN;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign if_valid       = w_if_valid;
  assign if_instr       = (w_if_valid && !w_head.misaligned) ? w_head.instr : NOP_INSTR;
  assign if_pc          = w_if_valid ? w_head.pc : '0;
  assign if_pc_plus4    = if_pc + 32'd4;
`ifdef IFETCH_MISALIGN_EXC_EN
  assign if_misaligned  = w_if_valid && w_head.misaligned;
`endif

endmodule
